// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter: round-robin sequencer that lets N_REQ requesters share one
// signed 8x8 multiplier. Operands are accepted over valid/ready, the product is
// captured after MUL_LAT cycles and returned with its requester ID.
//
// state | meaning
// IDLE  | looking for a requester; grant, start and operands are combinational here
// WAIT  | multiplier in flight; counter runs down to the capture cycle
// RESP  | result held on res_*; waits for res_ready, no new grant
module mult_share_arbiter #(
  parameter int N_REQ   = 4,
  parameter int ID_W    = 2,
  parameter int MUL_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [8*N_REQ-1:0]   req_a,
  input  logic [8*N_REQ-1:0]   req_b,
  output logic [N_REQ-1:0]     req_ready,
  output logic                 mul_start,
  output logic [7:0]           mul_a,
  output logic [7:0]           mul_b,
  input  logic [31:0]          mul_result,
  output logic                 res_valid,
  output logic [ID_W-1:0]      res_id,
  output logic [31:0]          res_data,
  input  logic                 res_ready,
  output logic                 busy
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          state;
  logic [ID_W-1:0] rr_ptr;
  logic [2:0]      cnt;

  logic [2*N_REQ-1:0] valid_dbl;
  logic [N_REQ-1:0]   valid_rot;
  logic [ID_W-1:0]    offset;
  logic [ID_W:0]      win_sum;
  logic [ID_W-1:0]    winner;
  logic               found;
  logic               grant;

  // Round-robin pick: rotate the valid vector so rr_ptr sits at bit 0, take the
  // lowest set bit, then map the offset back to an absolute requester index.
  always_comb begin
    valid_dbl = {req_valid, req_valid};
    valid_rot = valid_dbl[{1'b0, rr_ptr} +: N_REQ];
    found     = 1'b0;
    offset    = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (valid_rot[k]) begin
        found  = 1'b1;
        offset = ID_W'(k);
      end
    end
    win_sum = {1'b0, rr_ptr} + {1'b0, offset};
    if (win_sum >= (ID_W+1)'(N_REQ)) begin
      win_sum = win_sum - (ID_W+1)'(N_REQ);
    end
    winner = win_sum[ID_W-1:0];
  end

  // Grant strobe and multiplier operands, live only in IDLE and never under reset
  // so a requester cannot see a handshake that the FSM then throws away.
  always_comb begin
    grant     = (state == IDLE) && found && !rst;
    req_ready = '0;
    mul_a     = '0;
    mul_b     = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant && (ID_W'(i) == winner)) begin
        req_ready[i] = 1'b1;
        mul_a        = req_a[8*i +: 8];
        mul_b        = req_b[8*i +: 8];
      end
    end
    mul_start = grant;
  end

  // Sequencer: grant in IDLE, count the multiplier latency down in WAIT, hold the
  // product in RESP until the consumer takes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      cnt       <= '0;
      res_valid <= 1'b0;
      res_id    <= '0;
      res_data  <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant) begin
            res_id <= winner;
            rr_ptr <= (winner == ID_W'(N_REQ - 1)) ? '0 : winner + 1'b1;
            cnt    <= 3'(MUL_LAT);
            busy   <= 1'b1;
            state  <= WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - 3'd1;
          if (cnt == 3'd1) begin
            res_data  <= mul_result;
            res_valid <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Bench for mult_share_arbiter: a 4-requester / latency-1 instance and a
// 3-requester / latency-3 instance, each with its own multiplier pipeline model.
module tb_mult_share_arbiter;
  localparam int N    = 4;
  localparam int LAT  = 1;
  localparam int N3   = 3;
  localparam int LAT3 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int cyc_n       = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  // instance A signals
  logic          rst;
  logic [N-1:0]  req_valid;
  logic [8*N-1:0] req_a, req_b;
  logic [N-1:0]  req_ready;
  logic          mul_start;
  logic [7:0]    mul_a, mul_b;
  logic [31:0]   mul_result;
  logic          res_valid;
  logic [1:0]    res_id;
  logic [31:0]   res_data;
  logic          res_ready;
  logic          busy;

  // instance B signals
  logic           rst3;
  logic [N3-1:0]  req_valid3;
  logic [8*N3-1:0] req_a3, req_b3;
  logic [N3-1:0]  req_ready3;
  logic           mul_start3;
  logic [7:0]     mul_a3, mul_b3;
  logic [31:0]    mul_result3;
  logic           res_valid3;
  logic [1:0]     res_id3;
  logic [31:0]    res_data3;
  logic           res_ready3;
  logic           busy3;

  mult_share_arbiter #(.N_REQ(N), .ID_W(2), .MUL_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_result(mul_result), .res_valid(res_valid), .res_id(res_id),
    .res_data(res_data), .res_ready(res_ready), .busy(busy)
  );

  mult_share_arbiter #(.N_REQ(N3), .ID_W(2), .MUL_LAT(LAT3)) dut3 (
    .clk(clk), .rst(rst3), .req_valid(req_valid3), .req_a(req_a3), .req_b(req_b3),
    .req_ready(req_ready3), .mul_start(mul_start3), .mul_a(mul_a3), .mul_b(mul_b3),
    .mul_result(mul_result3), .res_valid(res_valid3), .res_id(res_id3),
    .res_data(res_data3), .res_ready(res_ready3), .busy(busy3)
  );

  function automatic int smul(logic [7:0] a, logic [7:0] b);
    int x, y;
    x = int'($signed(a));
    y = int'($signed(b));
    return x * y;
  endfunction

  // first valid requester scanning from ptr, modulo n; -1 if none
  function automatic int rr_pick(logic [7:0] valid, int ptr, int n);
    for (int k = 0; k < n; k++) begin
      if (valid[(ptr + k) % n]) return (ptr + k) % n;
    end
    return -1;
  endfunction

  // multiplier models: product stable MUL_LAT cycles after the start cycle
  logic [31:0] pipe_a;
  logic [31:0] pipe_b [3];
  always @(posedge clk) begin
    pipe_a    <= smul(mul_a, mul_b);
    pipe_b[0] <= smul(mul_a3, mul_b3);
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
  end
  assign mul_result  = pipe_a;
  assign mul_result3 = pipe_b[LAT3-1];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: no response within cycle budget (t=%0t)", name, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_a();
    rst = 1'b1; req_valid = '0; res_ready = 1'b0; req_a = '0; req_b = '0;
    tick(); tick(); #1;
    chk("rst_res_valid", res_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_res_id", res_id, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_mul_start", mul_start, 0);
    chk("rst_mul_a", mul_a, 0);
    chk("rst_mul_b", mul_b, 0);
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_grant_a(output int at, output bit ok);
    ok = 1'b0; at = 0;
    for (int t = 0; t < 20; t++) begin
      if (req_ready != '0) begin ok = 1'b1; at = cyc_n; return; end
      tick(); #1;
    end
  endtask

  task automatic wait_res_a(output int dly, output bit ok);
    ok = 1'b0; dly = 0;
    for (int t = 0; t < 20; t++) begin
      tick(); #1; dly++;
      if (res_valid) begin ok = 1'b1; return; end
    end
  endtask

  task automatic wait_grant_b(output int at, output bit ok);
    ok = 1'b0; at = 0;
    for (int t = 0; t < 20; t++) begin
      if (req_ready3 != '0) begin ok = 1'b1; at = cyc_n; return; end
      tick(); #1;
    end
  endtask

  task automatic wait_res_b(output int dly, output bit ok);
    ok = 1'b0; dly = 0;
    for (int t = 0; t < 20; t++) begin
      tick(); #1; dly++;
      if (res_valid3) begin ok = 1'b1; return; end
    end
  endtask

  typedef struct {
    int          id;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [5];

  initial begin
    int at, last, dly, w, id;
    bit ok;
    logic [N-1:0] exp_ready, granted_prev;
    bit m_pending;
    int m_ptr, m_id, m_due;
    logic [31:0] m_data;

    tbl[0] = '{2, 8'hFD, 8'h07, 32'hFFFF_FFEB};
    tbl[1] = '{0, 8'h80, 8'h80, 32'h0000_4000};
    tbl[2] = '{1, 8'h80, 8'h7F, 32'hFFFF_C080};
    tbl[3] = '{3, 8'h7F, 8'h7F, 32'h0000_3F01};
    tbl[4] = '{2, 8'h00, 8'hFF, 32'h0000_0000};

    rst3 = 1'b1; req_valid3 = '0; req_a3 = '0; req_b3 = '0; res_ready3 = 1'b0;

    // single operations with boundary operands, consumer always ready
    reset_a();
    res_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      req_valid = 4'(1 << tbl[k].id);
      req_a = 32'(tbl[k].a) << (8 * tbl[k].id);
      req_b = 32'(tbl[k].b) << (8 * tbl[k].id);
      #1;
      chk("tbl_req_ready", req_ready, 32'(1 << tbl[k].id));
      chk("tbl_mul_start", mul_start, 1);
      chk("tbl_mul_a", mul_a, tbl[k].a);
      chk("tbl_mul_b", mul_b, tbl[k].b);
      chk("tbl_busy_idle", busy, 0);
      tick();
      req_valid = '0;
      #1;
      chk("tbl_wait_ready", req_ready, 0);
      chk("tbl_wait_start", mul_start, 0);
      chk("tbl_wait_busy", busy, 1);
      chk("tbl_wait_res_valid", res_valid, 0);
      tick(); #1;
      chk("tbl_res_valid", res_valid, 1);
      chk("tbl_res_id", res_id, tbl[k].id);
      chk("tbl_res_data", res_data, tbl[k].exp);
      chk("tbl_resp_busy", busy, 1);
      tick(); #1;
      chk("tbl_res_done", res_valid, 0);
      chk("tbl_idle_busy", busy, 0);
    end

    // fairness: everyone valid continuously
    reset_a();
    res_ready = 1'b1;
    req_a = {8'd4, 8'd3, 8'd2, 8'd1};
    req_b = {4{8'd10}};
    req_valid = 4'hF;
    #1;
    last = 0;
    for (int g = 0; g < 5; g++) begin
      wait_grant_a(at, ok);
      if (!ok) begin timeout("fair_grant"); break; end
      chk("fair_grant", req_ready, 32'(1 << (g % N)));
      if (g > 0) chk("fair_spacing", 32'(at - last), LAT + 2);
      last = at;
      wait_res_a(dly, ok);
      if (!ok) begin timeout("fair_res"); break; end
      chk("fair_latency", 32'(dly), LAT + 1);
      chk("fair_res_id", res_id, 32'(g % N));
      chk("fair_res_data", res_data, 32'(((g % N) + 1) * 10));
    end

    // backpressure: result held while requester 1 waits
    reset_a();
    res_ready = 1'b0;
    tick();
    req_valid = 4'b1000; req_a = 32'h0500_0000; req_b = 32'h0600_0000;
    #1;
    chk("bp_grant3", req_ready, 4'b1000);
    tick();
    req_valid = 4'b0010; req_a = 32'h0000_0900; req_b = 32'h0000_0B00;
    #1;
    chk("bp_wait_ready", req_ready, 0);
    tick(); #1;
    chk("bp_res_valid", res_valid, 1);
    chk("bp_res_id", res_id, 3);
    chk("bp_res_data", res_data, 30);
    for (int c = 0; c < 5; c++) begin
      tick(); #1;
      chk("bp_hold_valid", res_valid, 1);
      chk("bp_hold_id", res_id, 3);
      chk("bp_hold_data", res_data, 30);
      chk("bp_hold_ready", req_ready, 0);
      chk("bp_hold_busy", busy, 1);
    end
    tick();
    res_ready = 1'b1;
    #1;
    chk("bp_accept_cycle_ready", req_ready, 0);
    chk("bp_accept_cycle_valid", res_valid, 1);
    tick(); #1;
    chk("bp_released_valid", res_valid, 0);
    chk("bp_released_grant", req_ready, 4'b0010);
    chk("bp_released_mul_a", mul_a, 8'h09);
    tick();
    req_valid = '0;
    tick(); #1;
    chk("bp_second_id", res_id, 1);
    chk("bp_second_data", res_data, 99);

    // reset during WAIT: in-flight product discarded, pointer back to 0
    tick();
    req_valid = 4'b0100; req_a = 32'h0002_0000; req_b = 32'h0003_0000;
    #1;
    chk("mr_grant2", req_ready, 4'b0100);
    tick();
    req_valid = '0;
    #1;
    chk("mr_wait_busy", busy, 1);
    rst = 1'b1;
    tick(); #1;
    chk("mr_res_valid", res_valid, 0);
    chk("mr_busy", busy, 0);
    chk("mr_res_id", res_id, 0);
    chk("mr_res_data", res_data, 0);
    chk("mr_req_ready", req_ready, 0);
    chk("mr_mul_start", mul_start, 0);
    tick();
    rst = 1'b0;
    req_valid = 4'hF;
    req_a = {8'h01, 8'h01, 8'h01, 8'hF9};
    req_b = {8'h01, 8'h01, 8'h01, 8'h09};
    #1;
    chk("mr_no_late_res", res_valid, 0);
    chk("mr_first_grant", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    tick(); #1;
    chk("mr_res_id0", res_id, 0);
    chk("mr_res_data0", res_data, 32'hFFFF_FFC1);

    // randomized traffic against the arbitration model
    reset_a();
    granted_prev = '0;
    m_pending = 1'b0; m_ptr = 0; m_id = 0; m_due = 0; m_data = '0;
    for (int c = 0; c < 400; c++) begin
      tick();
      for (int i = 0; i < N; i++) begin
        if (granted_prev[i] || !req_valid[i]) begin
          req_valid[i] = ($urandom_range(0, 1) == 0);
          req_a[8*i +: 8] = 8'($urandom);
          req_b[8*i +: 8] = 8'($urandom);
        end else if ($urandom_range(0, 9) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      res_ready = ($urandom_range(0, 3) != 0);
      #1;
      exp_ready = '0;
      if (!m_pending) begin
        w = rr_pick(8'(req_valid), m_ptr, N);
        if (w >= 0) begin
          exp_ready = 4'(1 << w);
          m_pending = 1'b1;
          m_id = w;
          m_data = smul(req_a[8*w +: 8], req_b[8*w +: 8]);
          m_due = cyc_n + 1 + LAT;
          m_ptr = (w + 1) % N;
        end
      end
      chk("rnd_req_ready", req_ready, exp_ready);
      chk("rnd_res_valid", res_valid, (m_pending && cyc_n >= m_due) ? 1 : 0);
      if (m_pending && cyc_n >= m_due) begin
        chk("rnd_res_id", res_id, m_id);
        chk("rnd_res_data", res_data, m_data);
        if (res_ready) m_pending = 1'b0;
      end
      granted_prev = req_ready;
    end
    req_valid = '0;

    // latency 3, three requesters: pointer wrap and capture timing
    tick(); tick();
    #1;
    chk("b_rst_res_valid", res_valid3, 0);
    chk("b_rst_busy", busy3, 0);
    tick();
    rst3 = 1'b0;
    res_ready3 = 1'b1;
    req_a3 = {8'd4, 8'd3, 8'd2};
    req_b3 = {3{8'hFB}};
    req_valid3 = 3'b111;
    #1;
    last = 0;
    for (int g = 0; g < 5; g++) begin
      id = g % N3;
      wait_grant_b(at, ok);
      if (!ok) begin timeout("b_grant"); break; end
      chk("b_grant", req_ready3, 32'(1 << id));
      chk("b_mul_start", mul_start3, 1);
      if (g > 0) chk("b_spacing", 32'(at - last), LAT3 + 2);
      last = at;
      wait_res_b(dly, ok);
      if (!ok) begin timeout("b_res"); break; end
      chk("b_latency", 32'(dly), LAT3 + 1);
      chk("b_res_id", res_id3, id);
      chk("b_res_data", res_data3, 32'(-(id + 2) * 5));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
